// File: rtl/emib_conn_checker.sv
// -----------------------------------------------------------------------------
// emib_conn_checker
// Walking-one connectivity sequencer for the die-to-die EMIB channel model.
// Drives a single high pad per step onto the master-side AIB buses, samples the
// slave side, and auto-detects straight (ch N<->N) versus rotated
// (ch N<->NUM_CH-1-N) wiring from the first step that resolves.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          one-cycle pulse, starts a scan when idle
//   i_bit_en         per-pad enable; disabled pads are skipped
//   o_m_tx_aib       flattened master-side drive, channel c at [c*AIB_W +: AIB_W]
//   i_s_rx_aib       flattened slave-side observation, same packing
//   o_busy           scan in progress
//   o_done           level, set at scan end, cleared by the next accepted start
//   o_pass           zero errors and wiring mode resolved (valid with o_done)
//   o_rotated        rotated wiring detected (valid with o_done)
//   o_fail_ch        channel of the first failing step
//   o_fail_bit       pad of the first failing step
//   o_err_cnt        failing-step count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module emib_conn_checker #(
    parameter int unsigned NUM_CH     = 24,
    parameter int unsigned AIB_W      = 102,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [AIB_W-1:0]          i_bit_en,
    output logic [NUM_CH*AIB_W-1:0]   o_m_tx_aib,
    input  logic [NUM_CH*AIB_W-1:0]   i_s_rx_aib,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_pass,
    output logic                      o_rotated,
    output logic [4:0]                o_fail_ch,
    output logic [6:0]                o_fail_bit,
    output logic [15:0]               o_err_cnt
);

    localparam int unsigned TOT_W    = NUM_CH * AIB_W;
    localparam int unsigned IDX_W    = $clog2(TOT_W);
    localparam logic [4:0]  CH_LAST  = 5'(NUM_CH - 1);
    localparam logic [3:0]  SET_LAST = 4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_FIN
    } state_t;

    state_t             r_state;
    logic [4:0]         r_ch;
    logic [6:0]         r_bit;
    logic [3:0]         r_settle;
    logic               r_mode_res;
    logic               r_mode_rot;
    logic [TOT_W-1:0]   r_tx;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_rotated;
    logic [4:0]         r_fail_ch;
    logic [6:0]         r_fail_bit;
    logic [15:0]        r_err_cnt;

    logic [6:0]         w_first_bit;
    logic [6:0]         w_next_bit;
    logic               w_any_en;
    logic               w_has_next;
    logic [4:0]         w_rot_ch;
    logic [IDX_W-1:0]   w_idx_str;
    logic [IDX_W-1:0]   w_idx_rot;
    logic [TOT_W-1:0]   w_exp_str;
    logic [TOT_W-1:0]   w_exp_rot;
    logic               w_match_str;
    logic               w_match_rot;
    logic               w_step_err;

    // Lowest enabled pad overall, and lowest enabled pad above the current one
    always_comb begin
        w_first_bit = '0;
        w_any_en    = 1'b0;
        w_next_bit  = '0;
        w_has_next  = 1'b0;
        for (int i = int'(AIB_W) - 1; i >= 0; i--) begin
            if (i_bit_en[i]) begin
                w_first_bit = 7'(i);
                w_any_en    = 1'b1;
                if (7'(i) > r_bit) begin
                    w_next_bit = 7'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    // Expected one-hot images for both wiring hypotheses
    assign w_rot_ch  = CH_LAST - r_ch;
    assign w_idx_str = IDX_W'(r_ch) * IDX_W'(AIB_W) + IDX_W'(r_bit);
    assign w_idx_rot = IDX_W'(w_rot_ch) * IDX_W'(AIB_W) + IDX_W'(r_bit);
    assign w_exp_str = TOT_W'(1) << w_idx_str;
    assign w_exp_rot = TOT_W'(1) << w_idx_rot;

    assign w_match_str = (i_s_rx_aib == w_exp_str);
    assign w_match_rot = (i_s_rx_aib == w_exp_rot);

    // Before resolution a step fails only if neither hypothesis matches
    always_comb begin
        w_step_err = 1'b0;
        if (r_mode_res) begin
            w_step_err = r_mode_rot ? !w_match_rot : !w_match_str;
        end else begin
            w_step_err = !w_match_str && !w_match_rot;
        end
    end

    // Scan sequencer with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_ch       <= '0;
            r_bit      <= '0;
            r_settle   <= '0;
            r_mode_res <= 1'b0;
            r_mode_rot <= 1'b0;
            r_tx       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_rotated  <= 1'b0;
            r_fail_ch  <= '0;
            r_fail_bit <= '0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= '0;
                    if (i_start) begin
                        r_done     <= 1'b0;
                        r_err_cnt  <= '0;
                        r_fail_ch  <= '0;
                        r_fail_bit <= '0;
                        r_mode_res <= 1'b0;
                        r_mode_rot <= 1'b0;
                        r_ch       <= '0;
                        r_bit      <= w_first_bit;
                        if (w_any_en) begin
                            r_busy  <= 1'b1;
                            r_state <= ST_DRIVE;
                        end else begin
                            // Nothing to test: finish at once as a failure
                            r_done    <= 1'b1;
                            r_pass    <= 1'b0;
                            r_rotated <= 1'b0;
                            r_state   <= ST_FIN;
                        end
                    end
                end

                ST_DRIVE: begin
                    r_tx     <= w_exp_str;
                    r_settle <= '0;
                    if (SETTLE_CYC == 0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_state <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (r_settle == SET_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (!r_mode_res) begin
                        if (w_match_str) begin
                            r_mode_res <= 1'b1;
                            r_mode_rot <= 1'b0;
                        end else if (w_match_rot) begin
                            r_mode_res <= 1'b1;
                            r_mode_rot <= 1'b1;
                        end
                    end
                    if (w_step_err) begin
                        // A zero count means no error has been captured yet
                        if (r_err_cnt == 16'd0) begin
                            r_fail_ch  <= r_ch;
                            r_fail_bit <= r_bit;
                        end
                        if (r_err_cnt != 16'hFFFF) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                    end
                    r_state <= ST_NEXT;
                end

                ST_NEXT: begin
                    if (w_has_next) begin
                        r_bit   <= w_next_bit;
                        r_state <= ST_DRIVE;
                    end else if (r_ch == CH_LAST) begin
                        r_tx      <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= (r_err_cnt == 16'd0) && r_mode_res;
                        r_rotated <= r_mode_rot;
                        r_state   <= ST_FIN;
                    end else begin
                        r_bit   <= w_first_bit;
                        r_ch    <= r_ch + 5'd1;
                        r_state <= ST_DRIVE;
                    end
                end

                ST_FIN: begin
                    r_tx    <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_m_tx_aib = r_tx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_rotated  = r_rotated;
    assign o_fail_ch  = r_fail_ch;
    assign o_fail_bit = r_fail_bit;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: doc/emib_conn_checker.md
# emib_conn_checker

Self-checking connectivity sequencer for the die-to-die EMIB channel model. It drives a walking-one pattern into the master-side AIB buses, reads the slave-side buses back, and auto-detects whether the bridge is wired straight (ch N↔N) or rotated (ch N↔NUM_CH-1-N). It reports pass/fail, the first failing channel/bit and an error count. It sits in the DV bench between the master-side drive point and the slave-side observation point of the bridge, and runs once per `start`.

## Interface
- `NUM_CH`, default 24: channels per side; legal range 2..32.
- `AIB_W`, default 102: pads per channel.
- `SETTLE_CYC`, default 2: wait cycles between drive and sample; legal range 0..15.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a scan when idle.
- `bit_en`  in  AIB_W  static per-pad enable; 0 = pad skipped (for s→m direction pads); must be stable during a scan.
- `m_tx_aib`  out  NUM_CH*AIB_W  flattened master-side drive, channel c at `[c*AIB_W +: AIB_W]`.
- `s_rx_aib`  in  NUM_CH*AIB_W  flattened slave-side observation, same packing.
- `busy`  out  1  scan in progress.
- `done`  out  1  level; set at scan end, cleared by next accepted `start` or reset.
- `pass`  out  1  valid when `done`; 1 = zero errors and mode resolved.
- `rotated`  out  1  valid when `done`; 1 = rotated wiring detected.
- `fail_ch`  out  5  channel of the first error.
- `fail_bit`  out  7  pad of the first error.
- `err_cnt`  out  16  number of failing steps, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, NEXT, FIN.
- IDLE: `m_tx_aib`=0. `start` → clear `done`, `err_cnt`, the first-error capture and the mode; set c=0, b=first enabled pad; go to DRIVE. If no pad is enabled, go directly to FIN with `pass`=0.
- DRIVE: register the one-hot pattern, with only bit b of channel c high. Go to SETTLE, or go to SAMPLE if SETTLE_CYC=0.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: compare the whole `s_rx_aib` against expected.
  - Mode unresolved (first step only):
    - Observed equals one-hot at slave ch c → straight.
    - Else observed equals one-hot at slave ch NUM_CH-1-c → rotated.
    - Else error, and the mode stays unresolved.
  - Mode resolved: expected is one-hot at the mapped channel, bit b; any mismatch (missing, extra or stuck bit) = error.
  - Unresolved after the first step: the step is retried for mode resolution at each following step until resolved.
  - First error latches c→`fail_ch`, b→`fail_bit`; later errors only increment `err_cnt`.
- NEXT: advance b to the next enabled pad. On wrap past AIB_W-1, set b=first enabled pad and c=c+1. Past NUM_CH-1 → FIN, else → DRIVE.
- FIN: `m_tx_aib`=0, `done`=1, `pass`=(err_cnt==0 && mode resolved), `busy`=0; then return to IDLE.
- `start` while busy is ignored.
- Straight and rotated are indistinguishable only if NUM_CH is odd and c is the centre channel. The first step uses c=0, so the mode is always decidable.

## Timing
- Reset values: `m_tx_aib`=0, `busy`=0, `done`=0, `pass`=0, `rotated`=0, `fail_ch`=0, `fail_bit`=0, `err_cnt`=0. Reset mid-scan aborts, and these values appear the cycle after `reset` is sampled high.
- `start` sampled at edge t → `busy`=1 at t+1; the first pattern is visible on `m_tx_aib` at t+2.
- Per-step length: SETTLE_CYC+3 cycles (DRIVE, SETTLE×N, SAMPLE, NEXT).
- `s_rx_aib` is sampled in the SAMPLE cycle only; it must be stable SETTLE_CYC+1 cycles after drive.
- Scan length for K enabled pads: NUM_CH*K*(SETTLE_CYC+3)+1 cycles to `done`. Default with all pads enabled: 24*102*5+1 = 12241.
- `err_cnt` updates one cycle after SAMPLE; `done`, `pass` and `rotated` update together in FIN.

## Test plan
- Straight bridge, defaults, all `bit_en`=1, pulse `start` → `done` at cycle 12241, `pass`=1, `rotated`=0, `err_cnt`=0.
- Rotated bridge → `pass`=1, `rotated`=1, `err_cnt`=0.
- Straight bridge with slave ch5 pad 37 stuck at 0 → `pass`=0, `fail_ch`=5, `fail_bit`=37, `err_cnt`=1.
- Slave ch3 pad 10 shorted to ch3 pad 11 (OR) → `err_cnt`=2, `fail_ch`=3, `fail_bit`=10.
- `bit_en` with only bits 0..3 set and SETTLE_CYC=0 → `done` after 24*4*3+1 = 289 cycles, `pass`=1; assert `reset` at cycle 100 of a repeat run → all outputs at reset values next cycle, and a following `start` completes normally.
- `start` pulsed again mid-scan → ignored and scan length unchanged; all `bit_en`=0 → `done`=1 and `pass`=0 within 3 cycles.
